// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Covers the store-type encoding, the MMIO register offsets and the TXSTATUS bit fields.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_WORD = 2'b01,
        MW_HALF = 2'b10,
        MW_BYTE = 2'b11
    } memwrite_t;

    localparam logic [3:0] OFS_TXDATA   = 4'h0;
    localparam logic [3:0] OFS_TXSTATUS = 4'h4;
    localparam logic [3:0] OFS_CYCLE    = 4'h8;

    localparam int unsigned ST_OVERFLOW_BIT = 8;
    localparam int unsigned ST_EMPTY_BIT    = 5;
    localparam int unsigned ST_FULL_BIT     = 4;
    localparam int unsigned ST_COUNT_W      = 4;

endpackage

// File: rtl/tx_fifo.sv
// Small register-based FIFO. The head entry is driven straight from storage flops.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_c, pop_ok_c;

    assign empty = (count_q == CNT_W'(0));
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pop_ok_c  = pop && !empty;
        push_ok_c = push && (!full || pop_ok_c);
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; clearing the pointers discards the contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle MIPS core: word RAM with byte/half lanes
// plus an MMIO window holding a TX FIFO and a free-running cycle counter.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        misalign
);

    localparam int unsigned RAM_WORDS = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

    memwrite_t             mw_c;
    logic                  is_mmio_c, misaligned_c, store_c;
    logic [3:0]            ofs_c, be_c;
    logic [31:0]           lane_data_c;
    logic [ADDR_WIDTH-1:0] ram_idx_c;
    logic                  ram_we_c, push_c, pop_c;
    logic                  fifo_empty, fifo_full;
    logic [CNT_W-1:0]      fifo_count;
    logic [31:0]           status_c;

    logic [31:0] ram_q [RAM_WORDS];
    logic [31:0] cycle_q, cycle_d;
    logic        overflow_q, overflow_d;
    logic        misalign_q, misalign_d;

    assign mw_c      = memwrite_t'(memwrite);
    assign is_mmio_c = (addr[31:4] == MMIO_BASE[31:4]);
    assign ofs_c     = addr[3:0];
    assign ram_idx_c = addr[ADDR_WIDTH+1:2];

    // Lane enables, replicated store data and alignment check.
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'b0000;
        lane_data_c  = writedata;
        case (mw_c)
            MW_WORD: begin
                misaligned_c = (addr[1:0] != 2'b00);
                be_c         = 4'b1111;
            end
            MW_HALF: begin
                misaligned_c = addr[0];
                be_c         = addr[1] ? 4'b1100 : 4'b0011;
                lane_data_c  = {2{writedata[15:0]}};
            end
            MW_BYTE: begin
                be_c         = 4'b0001 << addr[1:0];
                lane_data_c  = {4{writedata[7:0]}};
            end
            default: ;
        endcase
        store_c = (mw_c != MW_NONE) && !misaligned_c;
    end

    assign ram_we_c = reset && store_c && !is_mmio_c;
    assign push_c   = store_c && is_mmio_c && (ofs_c == OFS_TXDATA);
    assign pop_c    = tx_valid && tx_ready;
    assign tx_valid = !fifo_empty;
    assign misalign = misalign_q;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (writedata[7:0]),
        .pop       (pop_c),
        .head      (tx_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we_c && be_c[i]) begin
                ram_q[ram_idx_c][8*i +: 8] <= lane_data_c[8*i +: 8];
            end
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        cycle_d    = cycle_q + 32'd1;
        misalign_d = misalign_q || ((mw_c != MW_NONE) && misaligned_c);
        if (store_c && is_mmio_c) begin
            case (ofs_c)
                OFS_TXDATA:   if (fifo_full && !pop_c) overflow_d = 1'b1;
                OFS_TXSTATUS: overflow_d = 1'b0;
                OFS_CYCLE:    cycle_d    = writedata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        status_c                   = '0;
        status_c[ST_OVERFLOW_BIT]  = overflow_q;
        status_c[ST_EMPTY_BIT]     = fifo_empty;
        status_c[ST_FULL_BIT]      = fifo_full;
        status_c[ST_COUNT_W-1:0]   = ST_COUNT_W'(fifo_count);
    end

    // Same-cycle read path required by the single-cycle core.
    always_comb begin
        readdata = ram_q[ram_idx_c];
        if (is_mmio_c) begin
            case (ofs_c)
                OFS_TXSTATUS: readdata = status_c;
                OFS_CYCLE:    readdata = cycle_q;
                default:      readdata = '0;
            endcase
        end
    end

endmodule
